mem_arbiter: RTL

Sequences and shares the single-port data memory between the microprogrammed CPU controller and a DMA requester. Accepts one access per requester at a time, grants in round-robin order, drives the memory for a fixed number of cycles, and returns read data. Produces the active-low `wait_` stall signal that the controller's branch-condition mux samples.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: CPU, DMA and memory-side signals of the memory arbiter.
interface mem_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 16
);
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wait_;
    logic [DW-1:0] cpu_rdata;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_wait_;
    logic [DW-1:0] dma_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          owner;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dma_req, dma_we, dma_addr, dma_wdata,
        input  mem_rdata,
        output cpu_wait_, cpu_rdata, dma_wait_, dma_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dma_req, dma_we, dma_addr, dma_wdata,
        output mem_rdata,
        input  cpu_wait_, cpu_rdata, dma_wait_, dma_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy, owner
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin CPU/DMA sequencer for a single-port data memory.
// Define MEM_ARB_DMA_EN to build the DMA requester; otherwise only the CPU is served.
module mem_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 16,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);
    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          owner_q, owner_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rd_q, cpu_rd_d;
    logic [DW-1:0] dma_rd_q, dma_rd_d;
    logic          dma_req;
    logic          gnt_dma;
`ifdef MEM_ARB_DMA_EN
    assign dma_req       = bus.dma_req;
    assign bus.dma_wait_ = !(bus.dma_req && !(state_q == DONE && owner_q));
    assign bus.dma_rdata = dma_rd_q;
`else
    logic unused_dma;
    assign unused_dma    = ^{bus.dma_req, dma_rd_q};
    assign dma_req       = 1'b0;
    assign bus.dma_wait_ = 1'b1;
    assign bus.dma_rdata = '0;
`endif
    // On a tie the requester that did not win last time gets the memory.
    assign gnt_dma = dma_req && (!bus.cpu_req || !last_q);
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b0;
            last_q   <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            cpu_rd_q <= '0;
            dma_rd_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            cpu_rd_q <= cpu_rd_d;
            dma_rd_q <= dma_rd_d;
        end
    end
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owner_d  = owner_q;
        last_d   = last_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cpu_rd_d = cpu_rd_q;
        dma_rd_d = dma_rd_q;
        case (state_q)
            IDLE: if (bus.cpu_req || dma_req) begin
                state_d = ACCESS;
                cnt_d   = LAT_M1;
                owner_d = gnt_dma;
                last_d  = gnt_dma;
                we_d    = gnt_dma ? bus.dma_we    : bus.cpu_we;
                addr_d  = gnt_dma ? bus.dma_addr  : bus.cpu_addr;
                wdata_d = gnt_dma ? bus.dma_wdata : bus.cpu_wdata;
            end
            ACCESS: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) begin
                    state_d  = DONE;
                    cpu_rd_d = (!we_q && !owner_q) ? bus.mem_rdata : cpu_rd_q;
                    dma_rd_d = (!we_q &&  owner_q) ? bus.mem_rdata : dma_rd_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
    assign bus.mem_en    = state_q == ACCESS;
    assign bus.mem_we    = state_q == ACCESS && we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = state_q != IDLE;
    assign bus.owner     = owner_q;
    assign bus.cpu_wait_ = !(bus.cpu_req && !(state_q == DONE && !owner_q));
    assign bus.cpu_rdata = cpu_rd_q;
endmodule
